key_entry_accumulator: RTL and testbench



---
 rtl/key_entry_accumulator.sv | 131 +++++++++++++
 tb/tb_key_entry_accumulator.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_entry_accumulator.sv
// Scan-code set 2 keypad entry: decodes make/break/extended byte sequences into a
// shift-in digit entry with backspace, clear and Enter-to-commit for the 7-segment path.
//
// state       | meaning
// S_IDLE      | waiting for a make code or a prefix byte
// S_BREAK     | F0 seen; next byte is a release code and is dropped
// S_EXT       | E0 seen; only keypad Enter (5A) acts
// S_EXT_BREAK | E0 F0 seen; next byte is an extended release and is dropped
module key_entry_accumulator #(
  parameter int DIGITS        = 4,
  parameter bit HEX_EN        = 1'b0,
  parameter bit CLR_ON_COMMIT = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   code,
  input  logic                         code_valid,
  output logic [4*DIGITS-1:0]          entry,
  output logic [$clog2(DIGITS+1)-1:0]  count,
  output logic [4*DIGITS-1:0]          value,
  output logic                         commit,
  output logic                         overflow
);

  localparam int CW = $clog2(DIGITS+1);
  localparam logic [CW-1:0] FULL = CW'(DIGITS);

  localparam logic [7:0] KEY_BREAK = 8'hF0;
  localparam logic [7:0] KEY_EXT   = 8'hE0;
  localparam logic [7:0] KEY_ENTER = 8'h5A;
  localparam logic [7:0] KEY_BKSP  = 8'h66;
  localparam logic [7:0] KEY_ESC   = 8'h76;

  typedef enum logic [1:0] {S_IDLE, S_BREAK, S_EXT, S_EXT_BREAK} state_t;
  state_t state;

  logic                  is_digit;
  logic [3:0]            digit;
  logic                  act_digit, act_bksp, act_esc, act_enter;
  logic [4*DIGITS+3:0]   shifted;

  assign shifted = {entry, digit};

  always_comb begin
    is_digit = 1'b1;
    digit    = 4'h0;
    case (code)
      8'h45, 8'h70: digit = 4'h0;
      8'h16, 8'h69: digit = 4'h1;
      8'h1E, 8'h72: digit = 4'h2;
      8'h26, 8'h7A: digit = 4'h3;
      8'h25, 8'h6B: digit = 4'h4;
      8'h2E, 8'h73: digit = 4'h5;
      8'h36, 8'h74: digit = 4'h6;
      8'h3D, 8'h6C: digit = 4'h7;
      8'h3E, 8'h75: digit = 4'h8;
      8'h46, 8'h7D: digit = 4'h9;
      8'h1C: begin digit = 4'hA; is_digit = HEX_EN; end
      8'h32: begin digit = 4'hB; is_digit = HEX_EN; end
      8'h21: begin digit = 4'hC; is_digit = HEX_EN; end
      8'h23: begin digit = 4'hD; is_digit = HEX_EN; end
      8'h24: begin digit = 4'hE; is_digit = HEX_EN; end
      8'h2B: begin digit = 4'hF; is_digit = HEX_EN; end
      default: is_digit = 1'b0;
    endcase
  end

  // Enter is accepted both bare (main keyboard) and after E0 (keypad)
  always_comb begin
    act_digit = code_valid && (state == S_IDLE) && is_digit;
    act_bksp  = code_valid && (state == S_IDLE) && (code == KEY_BKSP);
    act_esc   = code_valid && (state == S_IDLE) && (code == KEY_ESC);
    act_enter = code_valid && ((state == S_IDLE) || (state == S_EXT)) && (code == KEY_ENTER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      entry    <= '0;
      count    <= '0;
      value    <= '0;
      commit   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      commit <= 1'b0;

      if (code_valid) begin
        unique case (state)
          S_IDLE: begin
            if (code == KEY_BREAK)    state <= S_BREAK;
            else if (code == KEY_EXT) state <= S_EXT;
          end
          S_BREAK:     state <= S_IDLE;
          S_EXT:       state <= (code == KEY_BREAK) ? S_EXT_BREAK : S_IDLE;
          S_EXT_BREAK: state <= S_IDLE;
        endcase
      end

      if (act_digit) begin
        if (count < FULL) begin
          entry <= shifted[4*DIGITS-1:0];
          count <= count + CW'(1);
        end else begin
          overflow <= 1'b1;
        end
      end

      if (act_bksp && (count != '0)) begin
        entry <= entry >> 4;
        count <= count - CW'(1);
      end

      if (act_esc) begin
        entry    <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end

      if (act_enter) begin
        value    <= entry;
        commit   <= 1'b1;
        overflow <= 1'b0;
        if (CLR_ON_COMMIT) begin
          entry <= '0;
          count <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_key_entry_accumulator.sv
// Bench for key_entry_accumulator: two configurations driven by the same byte stream,
// each checked every cycle against a digit-list model plus directed literal checks.
module tb_key_entry_accumulator;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       code_valid = 1'b0;
  logic [7:0] code = 8'h00;

  logic [15:0] ent0, val0;
  logic [2:0]  cnt0;
  logic        com0, ovf0;
  logic [11:0] ent1, val1;
  logic [1:0]  cnt1;
  logic        com1, ovf1;

  always #5 clk = ~clk;

  key_entry_accumulator #(.DIGITS(4), .HEX_EN(1'b0), .CLR_ON_COMMIT(1'b1)) u0 (
    .clk(clk), .reset(reset), .code(code), .code_valid(code_valid),
    .entry(ent0), .count(cnt0), .value(val0), .commit(com0), .overflow(ovf0));

  key_entry_accumulator #(.DIGITS(3), .HEX_EN(1'b1), .CLR_ON_COMMIT(1'b0)) u1 (
    .clk(clk), .reset(reset), .code(code), .code_valid(code_valid),
    .entry(ent1), .count(cnt1), .value(val1), .commit(com1), .overflow(ovf1));

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // model: m_dig[k][0] is the newest digit
  int nd_of [2] = '{4, 3};
  bit hex_of[2] = '{1'b0, 1'b1};
  bit clr_of[2] = '{1'b1, 1'b0};
  int m_dig [2][8];
  int m_cnt [2];
  logic [31:0] m_val [2];
  bit m_com [2];
  bit m_ovf [2];
  int m_pre [2];   // 0 none, 1 after F0, 2 after E0, 3 after E0 F0

  logic [7:0] top_keys[10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
  logic [7:0] pad_keys[10] = '{8'h70,8'h69,8'h72,8'h7A,8'h6B,8'h73,8'h74,8'h6C,8'h75,8'h7D};
  logic [7:0] hex_keys[6]  = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B};

  function automatic int digit_of(input logic [7:0] c, input bit hex);
    for (int i = 0; i < 10; i++) if (c == top_keys[i] || c == pad_keys[i]) return i;
    if (hex) for (int i = 0; i < 6; i++) if (c == hex_keys[i]) return 10 + i;
    return -1;
  endfunction

  function automatic logic [31:0] m_entry(input int k);
    logic [31:0] v = 0;
    for (int i = 0; i < nd_of[k]; i++) v = v + (32'(m_dig[k][i]) << (4 * i));
    return v;
  endfunction

  task automatic m_clear(input int k);
    for (int i = 0; i < 8; i++) m_dig[k][i] = 0;
    m_cnt[k] = 0;
  endtask

  task automatic m_enter(input int k);
    m_val[k] = m_entry(k);
    m_com[k] = 1'b1;
    m_ovf[k] = 1'b0;
    if (clr_of[k]) m_clear(k);
  endtask

  task automatic model_step(input int k);
    int d;
    m_com[k] = 1'b0;
    if (reset) begin
      m_clear(k); m_val[k] = 0; m_ovf[k] = 1'b0; m_pre[k] = 0;
      return;
    end
    if (!code_valid) return;
    case (m_pre[k])
      0: begin
        d = digit_of(code, hex_of[k]);
        if (code == 8'hF0) m_pre[k] = 1;
        else if (code == 8'hE0) m_pre[k] = 2;
        else if (d >= 0) begin
          if (m_cnt[k] < nd_of[k]) begin
            for (int i = nd_of[k] - 1; i > 0; i--) m_dig[k][i] = m_dig[k][i-1];
            m_dig[k][0] = d;
            m_cnt[k]++;
          end else m_ovf[k] = 1'b1;
        end else if (code == 8'h66) begin
          if (m_cnt[k] > 0) begin
            for (int i = 0; i < nd_of[k] - 1; i++) m_dig[k][i] = m_dig[k][i+1];
            m_dig[k][nd_of[k]-1] = 0;
            m_cnt[k]--;
          end
        end else if (code == 8'h76) begin
          m_clear(k); m_ovf[k] = 1'b0;
        end else if (code == 8'h5A) m_enter(k);
      end
      2: begin
        m_pre[k] = (code == 8'hF0) ? 3 : 0;
        if (code == 8'h5A) m_enter(k);
      end
      default: m_pre[k] = 0;
    endcase
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("u0.entry",    32'(ent0), m_entry(0));
      chk("u0.count",    32'(cnt0), 32'(m_cnt[0]));
      chk("u0.value",    32'(val0), m_val[0]);
      chk("u0.commit",   32'(com0), 32'(m_com[0]));
      chk("u0.overflow", 32'(ovf0), 32'(m_ovf[0]));
      chk("u1.entry",    32'(ent1), m_entry(1));
      chk("u1.count",    32'(cnt1), 32'(m_cnt[1]));
      chk("u1.value",    32'(val1), m_val[1]);
      chk("u1.commit",   32'(com1), 32'(m_com[1]));
      chk("u1.overflow", 32'(ovf1), 32'(m_ovf[1]));
    end
  end

  task automatic put(input logic v, input logic [7:0] c, input logic r);
    code_valid = v;
    code       = c;
    reset      = r;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] c);
    put(1'b1, c, 1'b0);
  endtask

  task automatic idle();
    put(1'b0, 8'h00, 1'b0);
  endtask

  logic [7:0] pool[16] = '{8'h16,8'h1E,8'h45,8'h7D,8'h69,8'h3E,8'hF0,8'hE0,
                           8'h5A,8'h66,8'h76,8'h1C,8'h2B,8'h24,8'hF0,8'h66};

  initial begin
    put(1'b0, 8'h00, 1'b1);
    put(1'b0, 8'h00, 1'b1);
    chk_en = 1'b1;
    chk("reset.entry", 32'(ent0), 32'h0);
    chk("reset.value", 32'(val0), 32'h0);
    chk("reset.count", 32'(cnt0), 32'h0);

    send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
    chk("lit.entry1234",  32'(ent0), 32'h1234);
    chk("lit.model1234",  m_entry(0), 32'h1234);
    chk("lit.count4",     32'(cnt0), 32'd4);
    chk("lit.ovf0",       32'(ovf0), 32'd0);
    send(8'h2E);
    chk("lit.entry_full", 32'(ent0), 32'h1234);
    chk("lit.ovf_set",    32'(ovf0), 32'd1);
    chk("lit.u1_ovf_set", 32'(ovf1), 32'd1);
    send(8'h5A);
    chk("lit.value1234",  32'(val0), 32'h1234);
    chk("lit.commit_hi",  32'(com0), 32'd1);
    chk("lit.ovf_clr",    32'(ovf0), 32'd0);
    chk("lit.entry_clr",  32'(ent0), 32'h0);
    idle();
    chk("lit.commit_lo",  32'(com0), 32'd0);
    chk("lit.model_com",  32'(m_com[0]), 32'd0);

    send(8'h16); send(8'hF0); send(8'h16); send(8'h1E); send(8'hF0); send(8'h1E);
    chk("lit.entry12",    32'(ent0), 32'h0012);
    chk("lit.count2",     32'(cnt0), 32'd2);
    send(8'h66);
    chk("lit.bksp1",      32'(ent0), 32'h0001);
    send(8'h66); send(8'h66);
    chk("lit.bksp_empty", 32'(ent0), 32'h0);
    chk("lit.count0",     32'(cnt0), 32'd0);

    send(8'h69); send(8'hE0); send(8'h5A);
    chk("lit.kp_value",   32'(val0), 32'h0001);
    chk("lit.kp_commit",  32'(com0), 32'd1);
    send(8'hE0); send(8'hF0); send(8'h5A);
    chk("lit.ext_brk",    32'(com0), 32'd0);
    send(8'h1E);
    chk("lit.after_ext",  32'(ent0), 32'h0002);

    send(8'h76);
    send(8'h1C);
    chk("lit.hex_off",    32'(ent0), 32'h0);
    send(8'h2B);
    chk("lit.hex_on",     32'(ent1), 32'h0AF);
    send(8'h5A);
    chk("lit.keep_val",   32'(val1), 32'h0AF);
    chk("lit.keep_ent",   32'(ent1), 32'h0AF);

    send(8'h16); send(8'hF0);
    put(1'b1, 8'h16, 1'b1);
    chk("lit.rst_entry",  32'(ent0), 32'h0);
    chk("lit.rst_value",  32'(val0), 32'h0);
    chk("lit.rst_ovf1",   32'(ovf1), 32'h0);
    send(8'h16);
    chk("lit.rst_idle",   32'(ent0), 32'h0001);

    for (int n = 0; n < 4000; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2) put(1'($urandom_range(0, 1)), 8'h16, 1'b1);
      else if (r < 25) put(1'b0, 8'($urandom_range(0, 255)), 1'b0);
      else if (r < 32) send(8'($urandom_range(0, 255)));
      else send(pool[$urandom_range(0, 15)]);
    end
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
